stepper_bus_sequencer: RTL

STEPPER_BUS_SEQUENCER -- requirements
Module: stepper_bus_sequencer

---
 rtl/stepper_pkg.sv | 55 +++++
 rtl/rr_arbiter.sv | 27 ++
 rtl/stepper_bus_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared types and tables for the stepper bus sequencer: FSM states, current codes
// and the 12-position electrical cycle lookup.
package stepper_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE_A = 2'd1,
      WRITE_B = 2'd2
   } state_t;

   localparam logic [4:0] DEFAULT_IDLE_ADDR = 5'd31;

   localparam logic [1:0] MAG_100 = 2'b00;
   localparam logic [1:0] MAG_67  = 2'b01;
   localparam logic [1:0] MAG_33  = 2'b10;
   localparam logic [1:0] MAG_0   = 2'b11;

   typedef struct packed {
      logic       phase;
      logic [1:0] mag;
   } coil_t;

   // Phase A coil drive for one electrical position; phase B uses a shifted index.
   function automatic coil_t phase_entry(input logic [3:0] idx);
      coil_t c;
      c.phase = 1'b0;
      c.mag   = MAG_0;
      case (idx)
         4'd0:  begin c.phase = 1'b0; c.mag = MAG_100; end
         4'd1:  begin c.phase = 1'b0; c.mag = MAG_67;  end
         4'd2:  begin c.phase = 1'b0; c.mag = MAG_33;  end
         4'd3:  begin c.phase = 1'b0; c.mag = MAG_0;   end
         4'd4:  begin c.phase = 1'b1; c.mag = MAG_33;  end
         4'd5:  begin c.phase = 1'b1; c.mag = MAG_67;  end
         4'd6:  begin c.phase = 1'b1; c.mag = MAG_100; end
         4'd7:  begin c.phase = 1'b1; c.mag = MAG_67;  end
         4'd8:  begin c.phase = 1'b1; c.mag = MAG_33;  end
         4'd9:  begin c.phase = 1'b0; c.mag = MAG_0;   end
         4'd10: begin c.phase = 1'b0; c.mag = MAG_33;  end
         4'd11: begin c.phase = 1'b0; c.mag = MAG_67;  end
         default: begin c.phase = 1'b0; c.mag = MAG_0; end
      endcase
      return c;
   endfunction

   function automatic logic [3:0] phase_b_index(input logic [3:0] pos);
      logic [4:0] s;
      s = {1'b0, pos} + 5'd9;
      if (s >= 5'd12) begin
         s = s - 5'd12;
      end
      return s[3:0];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: lowest-index pending requester at or above the pointer,
// wrapping past the top.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0] i_pending,
   input  logic [2:0]   i_ptr,
   output logic [2:0]   o_grant,
   output logic         o_valid
);

   always_comb begin : p_select
      int idx;
      idx     = 0;
      o_grant = 3'd0;
      o_valid = 1'b0;
      // Scan from the farthest offset down so the nearest pending one wins last.
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(i_ptr) + k) % N;
         if (i_pending[idx]) begin
            o_grant = idx[2:0];
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stepper_bus_sequencer.sv
// Tracks per-motor electrical position and serialises phase-latch writes for all
// motors onto one shared address/data bus.
module stepper_bus_sequencer
   import stepper_pkg::*;
#(
   parameter int         NUM_MOTORS = 4,
   parameter logic [4:0] BASE_ADDR  = 5'd0,
   parameter logic [4:0] IDLE_ADDR  = DEFAULT_IDLE_ADDR
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_MOTORS-1:0] step,
   input  logic [NUM_MOTORS-1:0] dir,
   input  logic [NUM_MOTORS-1:0] enable,
   output logic [4:0]            addr_bus,
   output logic                  I0_bus,
   output logic                  I1_bus,
   output logic                  Phase_bus,
   output logic                  busy
);

   state_t                r_state;
   logic [3:0]            r_pos [NUM_MOTORS];
   logic [NUM_MOTORS-1:0] r_pending;
   logic [NUM_MOTORS-1:0] r_en_prev;
   logic [2:0]            r_rr_ptr;
   logic [2:0]            r_snap_idx;
   logic [3:0]            r_snap_pos;
   logic                  r_snap_en;
   logic [4:0]            r_addr;
   logic                  r_i0;
   logic                  r_i1;
   logic                  r_phase;

   logic [2:0]            w_grant;
   logic                  w_grant_valid;
   logic                  w_take;
   logic [3:0]            w_grant_pos;
   logic                  w_grant_en;
   logic [NUM_MOTORS-1:0] w_accept;
   logic [NUM_MOTORS-1:0] w_set;
   logic [NUM_MOTORS-1:0] w_clear;
   coil_t                 w_coil_a;
   coil_t                 w_coil_b;
   coil_t                 w_coil_off;

   rr_arbiter #(.N(NUM_MOTORS)) u_arb (
      .i_pending (r_pending),
      .i_ptr     (r_rr_ptr),
      .o_grant   (w_grant),
      .o_valid   (w_grant_valid)
   );

   assign w_take = (r_state == IDLE) && w_grant_valid;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_MOTORS; gi++) begin : g_motor
         assign w_accept[gi] = step[gi] & enable[gi];
         assign w_set[gi]    = w_accept[gi] | (enable[gi] ^ r_en_prev[gi]);
         assign w_clear[gi]  = w_take && (w_grant == 3'(gi));
      end
   endgenerate

   always_comb begin
      w_grant_pos = 4'd0;
      w_grant_en  = 1'b0;
      for (int m = 0; m < NUM_MOTORS; m++) begin
         if (w_grant == 3'(m)) begin
            w_grant_pos = r_pos[m];
            w_grant_en  = enable[m];
         end
      end
   end

   assign w_coil_off.phase = 1'b0;
   assign w_coil_off.mag   = MAG_0;
   assign w_coil_a = w_grant_en ? phase_entry(w_grant_pos) : w_coil_off;
   assign w_coil_b = r_snap_en ? phase_entry(phase_b_index(r_snap_pos)) : w_coil_off;

   // A set request in the same cycle as its grant survives, so no step is lost.
   always_ff @(posedge clk) begin
      for (int m = 0; m < NUM_MOTORS; m++) begin
         if (!reset) begin
            r_pos[m]     <= 4'd0;
            r_pending[m] <= 1'b1;
            r_en_prev[m] <= enable[m];
         end else begin
            if (w_accept[m]) begin
               if (dir[m]) begin
                  r_pos[m] <= (r_pos[m] == 4'd11) ? 4'd0 : r_pos[m] + 4'd1;
               end else begin
                  r_pos[m] <= (r_pos[m] == 4'd0) ? 4'd11 : r_pos[m] - 4'd1;
               end
            end
            r_pending[m] <= (r_pending[m] & ~w_clear[m]) | w_set[m];
            r_en_prev[m] <= enable[m];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_rr_ptr   <= 3'd0;
         r_snap_idx <= 3'd0;
         r_snap_pos <= 4'd0;
         r_snap_en  <= 1'b0;
         r_addr     <= IDLE_ADDR;
         r_i0       <= 1'b0;
         r_i1       <= 1'b0;
         r_phase    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_valid) begin
                  r_state    <= WRITE_A;
                  r_snap_idx <= w_grant;
                  r_snap_pos <= w_grant_pos;
                  r_snap_en  <= w_grant_en;
                  r_rr_ptr   <= (w_grant == 3'(NUM_MOTORS - 1)) ? 3'd0 : w_grant + 3'd1;
                  r_addr     <= BASE_ADDR + 5'({w_grant, 1'b0});
                  r_i0       <= w_coil_a.mag[0];
                  r_i1       <= w_coil_a.mag[1];
                  r_phase    <= w_coil_a.phase;
               end
            end
            WRITE_A: begin
               r_state <= WRITE_B;
               r_addr  <= BASE_ADDR + 5'({r_snap_idx, 1'b1});
               r_i0    <= w_coil_b.mag[0];
               r_i1    <= w_coil_b.mag[1];
               r_phase <= w_coil_b.phase;
            end
            WRITE_B: begin
               r_state <= IDLE;
               r_addr  <= IDLE_ADDR;
               r_i0    <= 1'b0;
               r_i1    <= 1'b0;
               r_phase <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_addr  <= IDLE_ADDR;
               r_i0    <= 1'b0;
               r_i1    <= 1'b0;
               r_phase <= 1'b0;
            end
         endcase
      end
   end

   assign addr_bus  = r_addr;
   assign I0_bus    = r_i0;
   assign I1_bus    = r_i1;
   assign Phase_bus = r_phase;
   assign busy      = (r_state != IDLE) || (r_pending != '0);

endmodule
